bus2_line_master: RTL and testbench

- Cache-side initiator for bus2 (A2/D2/C2), the opposite end of the memory controller.
- Accepts one line-read or line-write request from the cache core.
- Issues C2_READ_LINE / C2_WRITE_LINE, streams or collects the 16-byte line as 2-byte beats, waits for C2_RESPONSE, then returns the result to the core.

---
 rtl/bus2_line_master.sv | 176 +++++++++++++++++
 tb/tb_bus2_line_master.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus2_line_master.sv
// bus2 cache-side initiator: moves one 16-byte line per request across A2/D2/C2.
// Defining BUS2_TIMEOUT_EN adds a WAIT_RESP watchdog that completes with resp_err=1.
module bus2_line_master #(
   parameter int ADDR2_BUS_SIZE  = 15,
   parameter int DATA_BUS_SIZE   = 16,
   parameter int CTR2_BUS_SIZE   = 2,
   parameter int CACHE_LINE_SIZE = 16,
   parameter int TIMEOUT_CYCLES  = 256
) (
   input  logic                         CLK,
   input  logic                         RESET,
   inout  wire  [ADDR2_BUS_SIZE-1:0]    A2_WIRE,
   inout  wire  [DATA_BUS_SIZE-1:0]     D2_WIRE,
   inout  wire  [CTR2_BUS_SIZE-1:0]     C2_WIRE,
   input  logic                         req_valid,
   input  logic                         req_write,
   input  logic [ADDR2_BUS_SIZE-1:0]    req_addr,
   input  logic [8*CACHE_LINE_SIZE-1:0] req_wdata,
   output logic                         req_ready,
   output logic                         resp_valid,
   output logic [8*CACHE_LINE_SIZE-1:0] resp_rdata,
   output logic                         resp_err
);
   localparam int LW    = 8 * CACHE_LINE_SIZE;
   localparam int BEATS = LW / DATA_BUS_SIZE;
   localparam int BW    = $clog2(BEATS);
   localparam logic [CTR2_BUS_SIZE-1:0] C2_RESPONSE   = 1;
   localparam logic [CTR2_BUS_SIZE-1:0] C2_READ_LINE  = 2;
   localparam logic [CTR2_BUS_SIZE-1:0] C2_WRITE_LINE = 3;

   typedef enum logic [2:0] {S_IDLE, S_CMD, S_WDATA, S_WAIT, S_RDATA, S_DONE, S_TURN} state_t;

   state_t                    state_q, state_d;
   logic [BW-1:0]             beat_q, beat_d;
   logic [ADDR2_BUS_SIZE-1:0] addr_q, addr_d;
   logic                      write_q, write_d;
   logic [LW-1:0]             wdata_q, wdata_d;
   logic [LW-1:0]             rdata_q, rdata_d;
   logic [DATA_BUS_SIZE-1:0]  rbeat_q [BEATS];
   logic [DATA_BUS_SIZE-1:0]  rbeat_d [BEATS];
   logic [DATA_BUS_SIZE-1:0]  wbeat   [BEATS];
   logic [LW-1:0]             rline_d;
   logic [BW-1:0]             beat_inc;
   logic                      c2_resp;
`ifdef BUS2_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   logic [TW-1:0]             tmo_q, tmo_d;
   logic                      err_q, err_d;
`endif

   assign beat_inc = beat_q + BW'(1);
   // x/z on C2 compares as unknown and is treated as "no response"
   assign c2_resp  = (C2_WIRE == C2_RESPONSE);

   genvar gi;
   generate
      for (gi = 0; gi < BEATS; gi++) begin : g_beats
         assign wbeat[gi]                           = wdata_q[gi*DATA_BUS_SIZE +: DATA_BUS_SIZE];
         assign rline_d[gi*DATA_BUS_SIZE +: DATA_BUS_SIZE] = rbeat_d[gi];
      end
   endgenerate

   assign A2_WIRE    = (state_q == S_CMD) ? addr_q : 'z;
   assign C2_WIRE    = (state_q == S_CMD) ? (write_q ? C2_WRITE_LINE : C2_READ_LINE) : 'z;
   assign D2_WIRE    = ((state_q == S_CMD && write_q) || state_q == S_WDATA) ? wbeat[beat_q] : 'z;
   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = (state_q == S_DONE);
   assign resp_rdata = rdata_q;
`ifdef BUS2_TIMEOUT_EN
   assign resp_err   = (state_q == S_DONE) && err_q;
`else
   assign resp_err   = 1'b0;
`endif

   // Read beat capture: beat 0 rides on the RESPONSE edge, beats 1..7 follow
   always_comb begin
      rbeat_d = rbeat_q;
      if (state_q == S_WAIT && c2_resp && !write_q)
         rbeat_d[0] = D2_WIRE;
      else if (state_q == S_RDATA)
         rbeat_d[beat_inc] = D2_WIRE;
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      addr_d  = addr_q;
      write_d = write_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
`ifdef BUS2_TIMEOUT_EN
      tmo_d   = tmo_q;
      err_d   = err_q;
`endif
      case (state_q)
         S_IDLE: if (req_valid) begin
            addr_d  = req_addr;
            write_d = req_write;
            wdata_d = req_wdata;
            beat_d  = '0;
            state_d = S_CMD;
         end
         S_CMD: begin
`ifdef BUS2_TIMEOUT_EN
            tmo_d = '0;
`endif
            if (write_q) begin
               beat_d  = BW'(1);
               state_d = S_WDATA;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WDATA: begin
            if (beat_q == BW'(BEATS-1)) state_d = S_WAIT;
            else                        beat_d  = beat_inc;
         end
         S_WAIT: begin
            if (c2_resp) begin
`ifdef BUS2_TIMEOUT_EN
               err_d = 1'b0;
`endif
               beat_d  = '0;
               state_d = write_q ? S_DONE : S_RDATA;
`ifdef BUS2_TIMEOUT_EN
            end else if (tmo_q == TW'(TIMEOUT_CYCLES-1)) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               tmo_d = tmo_q + TW'(1);
`endif
            end
         end
         S_RDATA: begin
            // beat_q holds the last captured index; this edge captures beat_q+1
            if (beat_inc == BW'(BEATS-1)) begin
               rdata_d = rline_d;
               state_d = S_DONE;
            end else begin
               beat_d = beat_inc;
            end
         end
         S_DONE:  state_d = S_TURN;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         rdata_q <= '0;
`ifdef BUS2_TIMEOUT_EN
         tmo_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         rdata_q <= rdata_d;
`ifdef BUS2_TIMEOUT_EN
         tmo_q   <= tmo_d;
         err_q   <= err_d;
`endif
      end
   end

   always_ff @(posedge CLK) begin
      wdata_q <= wdata_d;
      rbeat_q <= rbeat_d;
   end
endmodule

// File: tb/tb_bus2_line_master.sv
// Randomised bench for bus2_line_master with a line-level memory model and an
// exact cycle schedule derived from the bus protocol.
module tb_bus2_line_master;
   localparam int AW  = 15;
   localparam int DW  = 16;
   localparam int CW  = 2;
   localparam int LW  = 128;
   localparam int TMO = 16;

   logic          clk = 1'b0;
   logic          rst;
   tri0 [AW-1:0]  a2_w;
   tri0 [DW-1:0]  d2_w;
   tri0 [CW-1:0]  c2_w;
   logic [DW-1:0] mem_d;
   logic          mem_d_oe;
   logic [CW-1:0] mem_c;
   logic          mem_c_oe;
   logic          req_valid, req_write, req_ready, resp_valid, resp_err;
   logic [AW-1:0] req_addr;
   logic [LW-1:0] req_wdata, resp_rdata;

   int            checks = 0;
   int            errors = 0;
   logic [LW-1:0] exp_rdata;
   logic [LW-1:0] mem_model [logic [AW-1:0]];

   assign d2_w = mem_d_oe ? mem_d : 'z;
   assign c2_w = mem_c_oe ? mem_c : 'z;

   always #5 clk = ~clk;

   bus2_line_master #(.ADDR2_BUS_SIZE(AW), .DATA_BUS_SIZE(DW), .CTR2_BUS_SIZE(CW),
                      .CACHE_LINE_SIZE(16), .TIMEOUT_CYCLES(TMO)) dut (
      .CLK(clk), .RESET(rst), .A2_WIRE(a2_w), .D2_WIRE(d2_w), .C2_WIRE(c2_w),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid),
      .resp_rdata(resp_rdata), .resp_err(resp_err));

   task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [LW-1:0] rand_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [DW-1:0] beat_of(input logic [LW-1:0] line, input int k);
      return line[k*DW +: DW];
   endfunction

   // Present a request and return at the negedge of the CMD cycle; exp_wait < 0 skips the spacing check
   task automatic issue(input bit wr, input logic [AW-1:0] addr, input logic [LW-1:0] line,
                        input bit hold, input int exp_wait);
      int w = 0;
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = line;
      while (!req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("accept_bound", (w < 20), 1);
      if (exp_wait >= 0) chk("b2b_spacing", w, exp_wait);
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      chk("cmd_a2", a2_w, addr);
      chk("cmd_c2", c2_w, wr ? 2'd3 : 2'd2);
      chk("cmd_d2", d2_w, wr ? beat_of(line, 0) : '0);
      chk("cmd_ready", req_ready, 0);
   endtask

   task automatic finish_resp(input string tag);
      chk({tag, "_valid"}, resp_valid, 1);
      chk({tag, "_rdata"}, resp_rdata, exp_rdata);
      chk({tag, "_err"}, resp_err, 0);
      @(negedge clk);
      chk({tag, "_turn_valid"}, resp_valid, 0);
      chk({tag, "_turn_ready"}, req_ready, 0);
      $display("txn %s done rdata=%h", tag, resp_rdata);
   endtask

   task automatic do_read(input logic [AW-1:0] addr, input int delay, input bit hold,
                          input int exp_wait, input bit abort3);
      logic [LW-1:0] line;
      line = mem_model.exists(addr) ? mem_model[addr] : rand_line();
      mem_model[addr] = line;
      issue(1'b0, addr, '0, hold, exp_wait);
      @(negedge clk);
      chk("rd_a2_rel", a2_w, '0);
      chk("rd_c2_rel", c2_w, '0);
      repeat (delay - 1) @(negedge clk);
      chk("rd_wait_valid", resp_valid, 0);
      for (int k = 0; k < 8; k++) begin
         mem_d_oe = 1'b1; mem_d = beat_of(line, k);
         mem_c_oe = (k == 0); mem_c = 2'd1;
         if (k == 7) chk("rd_beat7_valid", resp_valid, 0);
         if (abort3 && k == 3) begin
            @(posedge clk);
            #2 rst = 1'b1;
            #1;
            chk("rst_ready", req_ready, 1);
            chk("rst_valid", resp_valid, 0);
            chk("rst_rdata", resp_rdata, '0);
            chk("rst_a2", a2_w, '0);
            chk("rst_c2", c2_w, '0);
            @(negedge clk);
            rst = 1'b0; mem_d_oe = 1'b0; mem_c_oe = 1'b0;
            exp_rdata = '0;
            @(negedge clk);
            chk("rst_after_valid", resp_valid, 0);
            chk("rst_after_rdata", resp_rdata, '0);
            $display("txn read addr=%h aborted by reset", addr);
            return;
         end
         @(negedge clk);
      end
      mem_d_oe = 1'b0; mem_c_oe = 1'b0;
      exp_rdata = line;
      finish_resp("read");
   endtask

   task automatic do_write(input logic [AW-1:0] addr, input logic [LW-1:0] line, input int delay,
                           input bit hold, input int exp_wait);
      issue(1'b1, addr, line, hold, exp_wait);
      for (int k = 1; k < 8; k++) begin
         @(negedge clk);
         chk($sformatf("wr_d2_beat%0d", k), d2_w, beat_of(line, k));
         if (k == 1) begin
            chk("wr_a2_rel", a2_w, '0);
            chk("wr_c2_rel", c2_w, '0);
         end
      end
      @(negedge clk);
      chk("wr_d2_rel", d2_w, '0);
      repeat (delay - 1) @(negedge clk);
      chk("wr_wait_valid", resp_valid, 0);
      mem_c_oe = 1'b1; mem_c = 2'd1;
      @(negedge clk);
      mem_c_oe = 1'b0;
      mem_model[addr] = line;
      finish_resp("write");
   endtask

   initial begin
      logic [LW-1:0] seq_line, a_line;
      logic [AW-1:0] addrs [4];
      bit            seen;
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      mem_d = '0; mem_d_oe = 1'b0; mem_c = '0; mem_c_oe = 1'b0; exp_rdata = '0;
      repeat (2) @(negedge clk);
      chk("reset_ready", req_ready, 1);
      chk("reset_valid", resp_valid, 0);
      chk("reset_err", resp_err, 0);
      chk("reset_rdata", resp_rdata, '0);
      chk("reset_buses", {a2_w, d2_w, c2_w}, '0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 16; i++) seq_line[i*8 +: 8] = 8'(i);
      mem_model[15'h0012] = seq_line;
      do_read(15'h0012, 100, 1'b0, -1, 1'b0);

      for (int i = 0; i < 16; i++) a_line[i*8 +: 8] = 8'(8'hA0 + i);
      do_write(15'h7FFF, a_line, 5, 1'b0, -1);
      do_read(15'h7FFF, 3, 1'b0, -1, 1'b0);

      // back-to-back with req_valid held: TURN, then IDLE, then CMD
      do_read(15'h0012, 4, 1'b1, -1, 1'b0);
      do_write(15'h0444, rand_line(), 2, 1'b1, 1);
      do_read(15'h0444, 1, 1'b0, 1, 1'b0);

      addrs[0] = 15'($urandom); addrs[1] = 15'($urandom);
      addrs[2] = 15'($urandom); addrs[3] = 15'h0012;
      for (int i = 0; i < 10; i++) begin
         if ($urandom_range(1, 0) == 1)
            do_write(addrs[$urandom_range(3, 0)], rand_line(), $urandom_range(8, 1), 1'b0, -1);
         else
            do_read(addrs[$urandom_range(3, 0)], $urandom_range(8, 1), 1'b0, -1, 1'b0);
      end

      do_read(addrs[0], 6, 1'b0, -1, 1'b1);
      do_read(addrs[1], 2, 1'b0, -1, 1'b0);

      mem_c_oe = 1'b1; mem_c = 2'd1;
      repeat (3) begin
         @(negedge clk);
         chk("spurious_ready", req_ready, 1);
         chk("spurious_valid", resp_valid, 0);
      end
      mem_c_oe = 1'b0;
      do_read(15'h0012, 7, 1'b0, -1, 1'b0);

`ifdef BUS2_TIMEOUT_EN
      issue(1'b0, 15'h0055, '0, 1'b0, -1);
      seen = 1'b0;
      for (int i = 1; i <= TMO; i++) begin
         @(negedge clk);
         seen |= resp_valid;
      end
      chk("tmo_early", seen, 0);
      @(negedge clk);
      chk("tmo_valid", resp_valid, 1);
      chk("tmo_err", resp_err, 1);
      chk("tmo_rdata", resp_rdata, exp_rdata);
      @(negedge clk);
      chk("tmo_turn", resp_valid, 0);
      $display("txn timeout read done err=1");
`else
      issue(1'b0, 15'h0055, '0, 1'b0, -1);
      seen = 1'b0;
      repeat (1000) begin
         @(negedge clk);
         seen |= resp_valid;
      end
      chk("no_timeout", seen, 0);
      chk("no_timeout_busy", req_ready, 0);
      $display("txn silent read still pending after 1000 cycles");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
`endif
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
